// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock with timeout/retry,
// qualifies lock stability and holds the system in reset until the PLL clocks are trustworthy.
module pll_reset_ctrl #(
    parameter int SYNC_STAGES   = 2,
    parameter int RST_PULSE     = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pll_locked,
    output logic                 pll_areset,
    output logic                 sys_reset,
    output logic                 ready,
    output logic [CNT_WIDTH-1:0] retry_count,
    output logic [CNT_WIDTH-1:0] loss_count
);

    localparam int MAX_AB  = (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] RST_LAST     = TW'(RST_PULSE - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RUN
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [TW-1:0]          timer;
    logic [TW-1:0]          timer_nxt;
    logic                   retry_inc;
    logic                   loss_inc;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lk;

    // pll_locked comes from another clock domain, so it is synchronised before use.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign lk = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        retry_inc = 1'b0;
        loss_inc  = 1'b0;
        case (state)
            PLL_RST: begin
                if (timer == RST_LAST) begin
                    state_nxt = WAIT_LOCK;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            WAIT_LOCK: begin
                // A lock seen on the timeout cycle wins over the retry.
                if (lk) begin
                    state_nxt = STABLE;
                    timer_nxt = '0;
                end else if (timer == TIMEOUT_LAST) begin
                    state_nxt = PLL_RST;
                    timer_nxt = '0;
                    retry_inc = 1'b1;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            STABLE: begin
                if (!lk) begin
                    state_nxt = WAIT_LOCK;
                    timer_nxt = '0;
                end else if (timer == STABLE_LAST) begin
                    state_nxt = RUN;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            RUN: begin
                if (!lk) begin
                    state_nxt = PLL_RST;
                    timer_nxt = '0;
                    loss_inc  = 1'b1;
                end
            end
            default: begin
                state_nxt = PLL_RST;
                timer_nxt = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= PLL_RST;
            timer       <= '0;
            pll_areset  <= 1'b1;
            sys_reset   <= 1'b1;
            ready       <= 1'b0;
            retry_count <= '0;
            loss_count  <= '0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            pll_areset <= (state_nxt == PLL_RST);
            sys_reset  <= (state_nxt != RUN);
            ready      <= (state_nxt == RUN);
            if (retry_inc && (retry_count != '1)) begin
                retry_count <= retry_count + 1'b1;
            end
            if (loss_inc && (loss_count != '1)) begin
                loss_count <= loss_count + 1'b1;
            end
        end
    end

endmodule
